// File: rtl/regfile_write_port_ctrl_pkg.sv
// Shared types and defaults for the register-file write-port controller.
// Optional forwarding lookup is enabled by REGFILE_WRITE_FORWARD_EN.
package regfile_write_port_ctrl_pkg;

  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_DEPTH         = 4;

  typedef struct packed {
    logic [DEF_ADDRESS_WIDTH-1:0] address;
    logic [DEF_DATA_WIDTH-1:0]    data;
  } wr_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/regfile_write_port_ctrl_if.sv
// Producer handshakes, register-file write bus and status of the write port.
// Lookup signals exist only with REGFILE_WRITE_FORWARD_EN.
interface regfile_write_port_ctrl_if
  import regfile_write_port_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int DEPTH         = DEF_DEPTH
) ();

  localparam int CW = cnt_width(DEPTH);

  logic                      aluValid;
  logic [ADDRESS_WIDTH-1:0]  aluAddress;
  logic [DATA_WIDTH-1:0]     aluData;
  logic                      aluReady;
  logic                      longValid;
  logic [ADDRESS_WIDTH-1:0]  longAddress;
  logic [DATA_WIDTH-1:0]     longData;
  logic                      longReady;
  logic [ADDRESS_WIDTH-1:0]  writeAddress;
  logic [DATA_WIDTH-1:0]     writeData;
  logic                      regWrite;
  logic [2**ADDRESS_WIDTH-1:0] pendingMask;
  logic [CW-1:0]             count;
`ifdef REGFILE_WRITE_FORWARD_EN
  logic [ADDRESS_WIDTH-1:0]  lookupAddress;
  logic                      lookupHit;
  logic [DATA_WIDTH-1:0]     lookupData;
`endif

  modport master (
    output aluValid, aluAddress, aluData,
    output longValid, longAddress, longData,
    input  aluReady, longReady,
    input  writeAddress, writeData, regWrite,
    input  pendingMask, count
`ifdef REGFILE_WRITE_FORWARD_EN
    ,
    output lookupAddress,
    input  lookupHit, lookupData
`endif
  );

  modport slave (
    input  aluValid, aluAddress, aluData,
    input  longValid, longAddress, longData,
    output aluReady, longReady,
    output writeAddress, writeData, regWrite,
    output pendingMask, count
`ifdef REGFILE_WRITE_FORWARD_EN
    ,
    input  lookupAddress,
    output lookupHit, lookupData
`endif
  );

endinterface

// File: rtl/regfile_write_fifo.sv
// In-order circular buffer of pending writes; entries exported oldest-first.
// Per-entry data is exported only with REGFILE_WRITE_FORWARD_EN.
module regfile_write_fifo
  import regfile_write_port_ctrl_pkg::*;
#(
  parameter int AW    = DEF_ADDRESS_WIDTH,
  parameter int DW    = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [AW-1:0]          addr_i,
  input  logic [DW-1:0]          data_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [CW-1:0]          count_o,
  output logic [DW-1:0]          head_data_o,
  output logic [DEPTH-1:0][AW-1:0] addr_o,
`ifdef REGFILE_WRITE_FORWARD_EN
  output logic [DEPTH-1:0][DW-1:0] data_o,
`endif
  output logic [DEPTH-1:0]       valid_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [PW-1:0]            wr_q, rd_q;
  logic [CW-1:0]            cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        addr_q[wr_q] <= addr_i;
        data_q[wr_q] <= data_i;
        wr_q         <= wr_q + PW'(1);
      end
      if (pop_i) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  assign full_o      = (cnt_q == CW'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign count_o     = cnt_q;
  assign head_data_o = data_q[rd_q];

  // Slot k holds the k-th oldest entry, so consumers see age order.
  always_comb begin
    addr_o  = '0;
    valid_o = '0;
`ifdef REGFILE_WRITE_FORWARD_EN
    data_o  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      addr_o[k]  = addr_q[rd_q + PW'(k)];
      valid_o[k] = (CW'(k) < cnt_q);
`ifdef REGFILE_WRITE_FORWARD_EN
      data_o[k]  = data_q[rd_q + PW'(k)];
`endif
    end
  end

endmodule

// File: rtl/regfile_write_port_ctrl.sv
// Arbitrates ALU and long-latency results into the register-file write port.
// REGFILE_WRITE_FORWARD_EN adds a youngest-match lookup over pending writes.
module regfile_write_port_ctrl
  import regfile_write_port_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int DEPTH         = DEF_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  regfile_write_port_ctrl_if.slave bus
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = cnt_width(DEPTH);

  logic                     full, empty, pop, push;
  logic                     long_xfer, alu_xfer;
  logic [AW-1:0]            sel_addr;
  logic [DW-1:0]            sel_data;
  logic [CW-1:0]            cnt;
  logic [DW-1:0]            head_data;
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0]         ent_valid;
`ifdef REGFILE_WRITE_FORWARD_EN
  logic [DEPTH-1:0][DW-1:0] ent_data;
`endif

  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          rw_q, rw_d;
  logic [2**AW-1:0] mask;

  // Readiness looks only at full: a same-cycle pop never frees a slot.
  assign bus.longReady = !full;
  assign bus.aluReady  = !full && !bus.longValid;
  assign long_xfer     = bus.longValid && !full;
  assign alu_xfer      = bus.aluValid && bus.aluReady;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    unique case (1'b1)
      long_xfer: begin
        sel_addr = bus.longAddress;
        sel_data = bus.longData;
      end
      alu_xfer: begin
        sel_addr = bus.aluAddress;
        sel_data = bus.aluData;
      end
      default: ;
    endcase
  end

  assign push = (long_xfer || alu_xfer) && (sel_addr != '0);
  assign pop  = !empty;

  regfile_write_fifo #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW)
  ) u_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (push),
    .addr_i      (sel_addr),
    .data_i      (sel_data),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (cnt),
    .head_data_o (head_data),
    .addr_o      (ent_addr),
`ifdef REGFILE_WRITE_FORWARD_EN
    .data_o      (ent_data),
`endif
    .valid_o     (ent_valid)
  );

  always_comb begin
    wa_d = wa_q;
    wd_d = wd_q;
    rw_d = 1'b0;
    if (pop) begin
      wa_d = ent_addr[0];
      wd_d = head_data;
      rw_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wa_q <= '0;
      wd_q <= '0;
      rw_q <= 1'b0;
    end else begin
      wa_q <= wa_d;
      wd_q <= wd_d;
      rw_q <= rw_d;
    end
  end

  always_comb begin
    mask = '0;
    for (int k = 0; k < DEPTH; k++)
      if (ent_valid[k]) mask[ent_addr[k]] = 1'b1;
    if (rw_q) mask[wa_q] = 1'b1;
    mask[0] = 1'b0;
  end

  assign bus.writeAddress = wa_q;
  assign bus.writeData    = wd_q;
  assign bus.regWrite     = rw_q;
  assign bus.pendingMask  = mask;
  assign bus.count        = cnt;

`ifdef REGFILE_WRITE_FORWARD_EN
  logic          lk_hit;
  logic [DW-1:0] lk_data;

  // Output stage is oldest; later FIFO slots override earlier matches.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    if (rw_q && wa_q == bus.lookupAddress) begin
      lk_hit  = 1'b1;
      lk_data = wd_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_valid[k] && ent_addr[k] == bus.lookupAddress) begin
        lk_hit  = 1'b1;
        lk_data = ent_data[k];
      end
    end
    if (bus.lookupAddress == '0) begin
      lk_hit  = 1'b0;
      lk_data = '0;
    end
  end

  assign bus.lookupHit  = lk_hit;
  assign bus.lookupData = lk_data;
`endif

endmodule

// File: tb/tb_regfile_write_port_ctrl.sv
// Bench for regfile_write_port_ctrl: queue-based model checked every cycle,
// plus literal checks on directed scenarios (REGFILE_WRITE_FORWARD_EN optional).
module tb_regfile_write_port_ctrl;
  import regfile_write_port_ctrl_pkg::*;

  localparam int AW    = DEF_ADDRESS_WIDTH;
  localparam int DW    = DEF_DATA_WIDTH;
  localparam int DEPTH = DEF_DEPTH;

  logic clock;
  logic reset;
  int   vectors = 0;
  int   errs    = 0;
  bit   chk_en  = 0;

  regfile_write_port_ctrl_if #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) bus ();

  regfile_write_port_ctrl #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ordered list of pending writes plus the presented write.
  wr_entry_t   q[$];
  bit          pv = 0;
  logic [AW-1:0] pa = '0;
  logic [DW-1:0] pd = '0;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        q.delete();
        pv = 0;
        pa = '0;
        pd = '0;
      end else begin
        automatic int  n     = q.size();
        automatic bit  room  = (n < DEPTH);
        automatic wr_entry_t e;
        pv = 0;
        if (n > 0) begin
          e  = q.pop_front();
          pv = 1;
          pa = e.address;
          pd = e.data;
        end
        if (room) begin
          if (bus.longValid) begin
            if (bus.longAddress != 0)
              q.push_back('{bus.longAddress, bus.longData});
          end else if (bus.aluValid && bus.aluAddress != 0) begin
            q.push_back('{bus.aluAddress, bus.aluData});
          end
        end
      end
    end
  end

  function automatic logic [31:0] exp_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i].address] = 1'b1;
    if (pv) m[pa] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        automatic bit room = (q.size() < DEPTH);
        chk("longReady", bus.longReady, room);
        chk("aluReady", bus.aluReady, room && !bus.longValid);
        chk("regWrite", bus.regWrite, pv);
        chk("writeAddress", bus.writeAddress, pa);
        chk("writeData", bus.writeData, pd);
        chk("count", bus.count, q.size());
        chk("pendingMask", bus.pendingMask, exp_mask());
`ifdef REGFILE_WRITE_FORWARD_EN
        begin
          automatic bit h = 0;
          automatic logic [DW-1:0] d = '0;
          if (pv && pa == bus.lookupAddress) begin h = 1; d = pd; end
          foreach (q[i])
            if (q[i].address == bus.lookupAddress) begin
              h = 1; d = q[i].data;
            end
          if (bus.lookupAddress == 0) begin h = 0; d = '0; end
          chk("lookupHit", bus.lookupHit, h);
          chk("lookupData", bus.lookupData, d);
        end
`endif
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.aluValid    = 1'b0;
    bus.aluAddress  = '0;
    bus.aluData     = '0;
    bus.longValid   = 1'b0;
    bus.longAddress = '0;
    bus.longData    = '0;
  endtask

  task automatic alu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.aluValid   = 1'b1;
    bus.aluAddress = a;
    bus.aluData    = d;
  endtask

  task automatic lng(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.longValid   = 1'b1;
    bus.longAddress = a;
    bus.longData    = d;
  endtask

  initial begin
    reset = 1'b0;
    idle();
`ifdef REGFILE_WRITE_FORWARD_EN
    bus.lookupAddress = 5'd7;
`endif
    #1 reset = 1'b1;
    #1;
    chk("rst regWrite", bus.regWrite, 1'b0);
    chk("rst count", bus.count, 0);
    chk("rst mask", bus.pendingMask, 32'h0);
    chk("rst writeAddress", bus.writeAddress, 0);
    chk("rst writeData", bus.writeData, 32'h0);
    chk_en = 1;
    step(); step();
    reset = 1'b0;
    step();

    // single ALU write to r5
    alu(5, 32'h12345678);
    #1 chk("t1 aluReady", bus.aluReady, 1'b1);
    step(); idle();
    chk("t1 count", bus.count, 1);
    chk("t1 regWrite early", bus.regWrite, 1'b0);
    chk("t1 mask q", bus.pendingMask, 32'h20);
    step();
    chk("t1 regWrite", bus.regWrite, 1'b1);
    chk("t1 wa", bus.writeAddress, 5);
    chk("t1 wd", bus.writeData, 32'h12345678);
    chk("t1 mask p", bus.pendingMask, 32'h20);
    step();
    chk("t1 regWrite off", bus.regWrite, 1'b0);
    chk("t1 mask off", bus.pendingMask, 32'h0);

    // long beats ALU
    lng(3, 32'hA); alu(4, 32'hB);
    #1 chk("t2 aluReady", bus.aluReady, 1'b0);
    chk("t2 longReady", bus.longReady, 1'b1);
    step();
    bus.longValid = 1'b0;
    #1 chk("t2 aluReady2", bus.aluReady, 1'b1);
    step(); idle();
    chk("t2 wa1", bus.writeAddress, 3);
    chk("t2 wd1", bus.writeData, 32'hA);
    step();
    chk("t2 wa2", bus.writeAddress, 4);
    chk("t2 wd2", bus.writeData, 32'hB);
    step();
    chk("t2 idle", bus.regWrite, 1'b0);

    // burst: 4 long writes back-to-back while ALU waits
    alu(12, 32'hC);
    for (int i = 0; i < 4; i++) begin
      lng(AW'(8 + i), DW'(32'h100 + i));
      #1 chk("t3 alu blocked", bus.aluReady, 1'b0);
      step();
    end
    bus.longValid = 1'b0;
    step(); idle();
    for (int i = 0; i < 4; i++) step();
    chk("t3 last wa", bus.writeAddress, 12);
    chk("t3 last wd", bus.writeData, 32'hC);

    // register 0 is dropped
    alu(0, 32'hFFFFFFFF);
    #1 chk("t4 aluReady", bus.aluReady, 1'b1);
    step(); idle();
    chk("t4 count", bus.count, 0);
    chk("t4 mask", bus.pendingMask, 32'h0);
    step();
    chk("t4 regWrite", bus.regWrite, 1'b0);

    // two writes to r7
    alu(7, 32'h1);
    step();
    alu(7, 32'h2);
    step(); idle();
    chk("t5 wd first", bus.writeData, 32'h1);
`ifdef REGFILE_WRITE_FORWARD_EN
    chk("t5 lookupHit", bus.lookupHit, 1'b1);
    chk("t5 lookupData", bus.lookupData, 32'h2);
`endif
    step();
    chk("t5 regWrite second", bus.regWrite, 1'b1);
    chk("t5 wd second", bus.writeData, 32'h2);
    step();

    // async reset mid-burst
    alu(20, 32'h20); step();
    alu(21, 32'h21); step();
    alu(22, 32'h22); step();
    #1 reset = 1'b1;
    idle();
    #1;
    chk("t6 regWrite", bus.regWrite, 1'b0);
    chk("t6 count", bus.count, 0);
    chk("t6 mask", bus.pendingMask, 32'h0);
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6 quiet", bus.regWrite, 1'b0);
    end
    alu(9, 32'h99);
    step(); idle();
    step();
    chk("t6 resume wa", bus.writeAddress, 9);
    chk("t6 resume wd", bus.writeData, 32'h99);
    step(); step();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
